// File: rtl/ulpi_link_ctrl.sv
// ULPI link-side controller: one FSM that arbitrates register reads/writes
// (immediate and extended addresses) against PHY-initiated receive traffic.
// The pad tristate lives outside; data_oe tells it when the link drives.
module ulpi_link_ctrl #(
  parameter bit EXT_ADDR_EN = 1'b1,
  parameter bit RXCMD_FWD   = 1'b1,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_busy,
  output logic       reg_done,
  output logic       reg_err,
  output logic [7:0] reg_rdata,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_is_cmd,
  output logic       rx_end,
  output logic [7:0] status,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe
);

  typedef enum logic [3:0] {
    IDLE, TX_CMD, TX_EXT, TX_DATA, TX_STP, RD_TA, RD_DATA, RX_TA, RX, RX_END
  } state_t;

  // Last counter value before giving up; the counter is 8 bits wide.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       we_q, ext_q, retry;
  logic [7:0] addr_q, wdata_q, cnt;
  logic       tx_state, timed_out, illegal, ext_req;
  logic [7:0] tx_byte;

  assign timed_out = (cnt == TO_LAST);
  assign ext_req   = (reg_addr > 8'h3F);
  assign illegal   = ext_req && !EXT_ADDR_EN;

  // Byte the link presents while it owns the bus; extended accesses use the
  // escape address 6'h2F followed by the full address byte.
  always_comb begin
    tx_state = 1'b0;
    tx_byte  = 8'h00;
    case (state)
      TX_CMD:  begin tx_state = 1'b1; tx_byte = {we_q ? 2'b10 : 2'b11, ext_q ? 6'h2F : addr_q[5:0]}; end
      TX_EXT:  begin tx_state = 1'b1; tx_byte = addr_q; end
      TX_DATA: begin tx_state = 1'b1; tx_byte = wdata_q; end
      TX_STP:  tx_state = 1'b1;
      default: ;
    endcase
  end

  // Drive is released combinationally the moment the PHY takes DIR.
  assign data_oe  = tx_state & ~ulpi_dir & ~rst;
  assign data_o   = data_oe ? tx_byte : 8'h00;
  assign ulpi_stp = rst | (state == TX_STP);

  // Main FSM: request latch, TX sequencing with abort/timeout, read capture, RX stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      ext_q     <= 1'b0;
      retry     <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      cnt       <= 8'h00;
      reg_busy  <= 1'b0;
      reg_done  <= 1'b0;
      reg_err   <= 1'b0;
      reg_rdata <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_is_cmd <= 1'b0;
      rx_end    <= 1'b0;
      status    <= 8'h00;
    end else begin
      reg_done  <= 1'b0;
      reg_err   <= 1'b0;
      rx_valid  <= 1'b0;
      rx_is_cmd <= 1'b0;
      rx_end    <= 1'b0;
      cnt       <= 8'h00;  // any state change restarts the wait counter
      case (state)
        IDLE: begin
          if (ulpi_dir) state <= RX_TA;
          else if (reg_req) begin
            if (illegal) begin
              reg_done <= 1'b1;
              reg_err  <= 1'b1;
            end else begin
              we_q     <= reg_we;
              ext_q    <= ext_req;
              addr_q   <= reg_addr;
              wdata_q  <= reg_wdata;
              reg_busy <= 1'b1;
              state    <= TX_CMD;
            end
          end
        end
        TX_CMD, TX_EXT, TX_DATA: begin
          if (ulpi_dir) begin
            // PHY won the bus before accepting: keep the request and replay it.
            retry <= 1'b1;
            state <= RX_TA;
          end else if (ulpi_nxt) begin
            if (state == TX_DATA)                state <= TX_STP;
            else if (state == TX_CMD && ext_q)   state <= TX_EXT;
            else                                 state <= we_q ? TX_DATA : RD_TA;
          end else if (timed_out) begin
            reg_done <= 1'b1;
            reg_err  <= 1'b1;
            reg_busy <= 1'b0;
            state    <= IDLE;
          end else cnt <= cnt + 8'd1;
        end
        TX_STP: begin
          reg_done <= 1'b1;
          reg_busy <= 1'b0;
          state    <= IDLE;
        end
        RD_TA: begin
          if (ulpi_dir) state <= RD_DATA;
          else if (timed_out) begin
            reg_done <= 1'b1;
            reg_err  <= 1'b1;
            reg_busy <= 1'b0;
            state    <= IDLE;
          end else cnt <= cnt + 8'd1;
        end
        RD_DATA: begin
          // First cycle captures the register; afterwards wait for the PHY to release.
          if (reg_busy) begin
            reg_rdata <= data_i;
            reg_done  <= 1'b1;
            reg_busy  <= 1'b0;
          end else if (!ulpi_dir) state <= IDLE;
        end
        RX_TA: state <= RX;
        RX: begin
          if (ulpi_dir) begin
            rx_data <= data_i;
            if (ulpi_nxt) rx_valid <= 1'b1;
            else begin
              status    <= data_i;
              rx_valid  <= RXCMD_FWD;
              rx_is_cmd <= 1'b1;
            end
          end else begin
            rx_end <= 1'b1;
            state  <= RX_END;
          end
        end
        RX_END: begin
          retry <= 1'b0;
          state <= retry ? TX_CMD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// Directed bench for ulpi_link_ctrl: the bench plays the PHY side by hand.
// A second instance (no extended addressing, RX CMD not forwarded) covers the
// illegal-address and RX CMD drop behaviour.
module tb_ulpi_link_ctrl;

  logic       clk = 1'b0;
  logic       rst, reg_req, req2, reg_we, ulpi_dir, ulpi_nxt;
  logic [7:0] reg_addr, reg_wdata, data_i;

  logic       reg_busy, reg_done, reg_err, rx_valid, rx_is_cmd, rx_end, ulpi_stp, data_oe;
  logic [7:0] reg_rdata, rx_data, status, data_o;
  logic       busy2, done2, err2, rx_valid2, rx_is_cmd2, rx_end2, stp2, oe2;
  logic [7:0] rdata2, rx_data2, status2, data_o2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ulpi_link_ctrl dut (
    .clk(clk), .rst(rst), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_busy(reg_busy), .reg_done(reg_done), .reg_err(reg_err),
    .reg_rdata(reg_rdata), .rx_data(rx_data), .rx_valid(rx_valid), .rx_is_cmd(rx_is_cmd),
    .rx_end(rx_end), .status(status), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
    .ulpi_stp(ulpi_stp), .data_i(data_i), .data_o(data_o), .data_oe(data_oe)
  );

  ulpi_link_ctrl #(.EXT_ADDR_EN(1'b0), .RXCMD_FWD(1'b0), .TIMEOUT(255)) dut2 (
    .clk(clk), .rst(rst), .reg_req(req2), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_busy(busy2), .reg_done(done2), .reg_err(err2),
    .reg_rdata(rdata2), .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_is_cmd(rx_is_cmd2),
    .rx_end(rx_end2), .status(status2), .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt),
    .ulpi_stp(stp2), .data_i(data_i), .data_o(data_o2), .data_oe(oe2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; reg_req = 1'b0; req2 = 1'b0; reg_we = 1'b0; reg_addr = 8'h00;
    reg_wdata = 8'h00; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; data_i = 8'h00;

    // Reset state
    cyc(); cyc();
    chk("rst_stp", ulpi_stp, 1);
    chk("rst_busy", reg_busy, 0);
    chk("rst_done", reg_done, 0);
    chk("rst_rdata", reg_rdata, 8'h00);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_status", status, 8'h00);
    chk("rst_oe", data_oe, 0);
    chk("rst_do", data_o, 8'h00);
    rst = 1'b0; #1;
    chk("post_rst_stp", ulpi_stp, 0);
    cyc();

    // Immediate write 0x04 <- 0x45
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h04; reg_wdata = 8'h45;
    cyc(); reg_req = 1'b0;
    chk("wr_busy", reg_busy, 1);
    chk("wr_cmd", data_o, 8'h84);
    chk("wr_oe", data_oe, 1);
    cyc(); ulpi_nxt = 1'b1;
    cyc(); ulpi_nxt = 1'b0;
    chk("wr_data", data_o, 8'h45);
    cyc(); ulpi_nxt = 1'b1;
    cyc(); ulpi_nxt = 1'b0;
    chk("wr_stp", ulpi_stp, 1);
    chk("wr_stp_do", data_o, 8'h00);
    cyc();
    chk("wr_done", reg_done, 1);
    chk("wr_err", reg_err, 0);
    chk("wr_stp_low", ulpi_stp, 0);
    chk("wr_idle", reg_busy, 0);
    cyc();
    chk("wr_done_pulse", reg_done, 0);

    // Extended read 0x80, PHY returns 0xA5
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = 8'h80;
    cyc(); reg_req = 1'b0;
    chk("xr_cmd", data_o, 8'hEF);
    ulpi_nxt = 1'b1;
    cyc(); ulpi_nxt = 1'b0;
    chk("xr_addr", data_o, 8'h80);
    ulpi_nxt = 1'b1;
    cyc(); ulpi_nxt = 1'b0;
    chk("xr_ta_oe", data_oe, 0);
    ulpi_dir = 1'b1;
    cyc(); data_i = 8'hA5;
    cyc();
    chk("xr_done", reg_done, 1);
    chk("xr_err", reg_err, 0);
    chk("xr_rdata", reg_rdata, 8'hA5);
    ulpi_dir = 1'b0; data_i = 8'h00;
    cyc(); cyc();
    chk("xr_idle", reg_busy, 0);

    // RX burst: RX CMD 0x1D, then data 0xC3, 0x00
    ulpi_dir = 1'b1;
    cyc(); cyc();
    data_i = 8'h1D; ulpi_nxt = 1'b0;
    cyc();
    chk("rx_cmd_v", rx_valid, 1);
    chk("rx_cmd_f", rx_is_cmd, 1);
    chk("rx_cmd_d", rx_data, 8'h1D);
    chk("rx_status", status, 8'h1D);
    chk("rx2_cmd_drop", rx_valid2, 0);
    chk("rx2_status", status2, 8'h1D);
    data_i = 8'hC3; ulpi_nxt = 1'b1;
    cyc();
    chk("rx_d0", {rx_valid, rx_is_cmd, rx_data}, {2'b10, 8'hC3});
    data_i = 8'h00;
    cyc();
    chk("rx_d1", {rx_valid, rx_is_cmd, rx_data}, {2'b10, 8'h00});
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
    cyc();
    chk("rx_end", rx_end, 1);
    chk("rx_end_v", rx_valid, 0);
    cyc();
    chk("rx_end_pulse", rx_end, 0);
    chk("rx_status_hold", status, 8'h1D);
    cyc();

    // Write 0x0A <- 0x5A aborted by DIR in TX_CMD, then retried
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h0A; reg_wdata = 8'h5A;
    cyc(); reg_req = 1'b0;
    chk("ab_cmd", data_o, 8'h8A);
    ulpi_dir = 1'b1; #1;
    chk("ab_oe_drop", data_oe, 0);
    chk("ab_do_drop", data_o, 8'h00);
    cyc();
    chk("ab_busy", reg_busy, 1);
    cyc();
    data_i = 8'h4E; ulpi_nxt = 1'b0;
    cyc();
    chk("ab_rx", {rx_valid, rx_is_cmd, rx_data}, {2'b11, 8'h4E});
    chk("ab_status", status, 8'h4E);
    ulpi_dir = 1'b0; data_i = 8'h00;
    cyc();
    chk("ab_rx_end", rx_end, 1);
    cyc();
    chk("ab_retry_cmd", data_o, 8'h8A);
    chk("ab_retry_oe", data_oe, 1);
    ulpi_nxt = 1'b1;
    cyc();
    chk("ab_retry_data", data_o, 8'h5A);
    cyc(); ulpi_nxt = 1'b0;
    chk("ab_retry_stp", ulpi_stp, 1);
    cyc();
    chk("ab_done", {reg_done, reg_err}, 2'b10);
    cyc();

    // Read 0x15 with NXT never asserted: timeout after 255 cycles
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = 8'h15;
    cyc(); reg_req = 1'b0;
    chk("to_cmd", data_o, 8'hD5);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(); n++;
      if (reg_done) break;
    end
    chk("to_cycles", n, 255);
    chk("to_err", reg_err, 1);
    chk("to_rdata_keep", reg_rdata, 8'hA5);
    cyc();

    // Illegal address on the instance without extended access
    req2 = 1'b1; reg_we = 1'b1; reg_addr = 8'h40;
    cyc(); req2 = 1'b0;
    chk("ill_done_err", {done2, err2}, 2'b11);
    chk("ill_busy", busy2, 0);
    chk("ill_oe", oe2, 0);
    cyc();
    chk("ill_pulse", done2, 0);
    chk("ill_quiet", oe2, 0);

    // Reset asserted mid TX_DATA
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 8'h04; reg_wdata = 8'h77;
    cyc(); reg_req = 1'b0; ulpi_nxt = 1'b1;
    cyc(); ulpi_nxt = 1'b0;
    chk("mr_data", data_o, 8'h77);
    rst = 1'b1; #1;
    chk("mr_stp_now", ulpi_stp, 1);
    chk("mr_oe_now", data_oe, 0);
    cyc();
    chk("mr_busy", reg_busy, 0);
    chk("mr_done", reg_done, 0);
    chk("mr_status", status, 8'h00);
    chk("mr_rdata", reg_rdata, 8'h00);
    chk("mr_do", data_o, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mr_no_done", reg_done, 0);
    end
    chk("mr_stp_low", ulpi_stp, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ulpi_link_ctrl.md
Name: ulpi_link_ctrl

Overview:
Parametrised ULPI link-side controller for the USB3300 sniffer: one 60 MHz-domain engine that arbitrates register reads, register writes (immediate and extended addresses) and receive traffic on the ULPI bus. It replaces the separate read/write sub-blocks and output mux with a single state machine. The controller also adds DIR-abort retry, an NXT timeout and a byte-stream RX capture port feeding the sniffer buffer. The tristate pad sits outside this block, controlled by data_oe.

Parameters:
EXT_ADDR_EN, 1, 1 enables extended register access (TXCMD addr 6'h2F plus address byte) for reg_addr > 8'h3F; 0 flags such requests as error
RXCMD_FWD, 1, 1 forwards RX CMD bytes on rx stream with rx_is_cmd=1; 0 drops them (status still updated)
TIMEOUT, 255, cycles to wait for NXT/DIR before abandoning a register access (8-bit counter width fixed, max 255)

Ports:
clk  in  1  ULPI 60 MHz clock from PHY
rst  in  1  synchronous active-high reset
reg_req  in  1  register access request, sampled when reg_busy=0
reg_we  in  1  1=write, 0=read
reg_addr  in  8  register address
reg_wdata  in  8  write data
reg_busy  out  1  access in progress
reg_done  out  1  one-cycle pulse on completion
reg_err  out  1  valid with reg_done; timeout or illegal address
reg_rdata  out  8  read data, held until next read completes
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid this cycle
rx_is_cmd  out  1  rx_data is an RX CMD byte
rx_end  out  1  one-cycle pulse after DIR falls ending an RX burst
status  out  8  last RX CMD byte (linestate = status[1:0], RxEvent = status[5:4])
ulpi_dir  in  1  PHY DIR
ulpi_nxt  in  1  PHY NXT
ulpi_stp  out  1  link STP
data_i  in  8  ULPI data from pad
data_o  out  8  ULPI data to pad
data_oe  out  1  drive enable, always equals ~ulpi_dir registered-state driven, never 1 while ulpi_dir=1

Behaviour:
- Reset: reg_busy=0, reg_done=0, reg_err=0, reg_rdata=0, rx_valid=0, rx_is_cmd=0, rx_end=0, status=0, data_o=0, data_oe=0; ulpi_stp=1 during reset, 0 from first cycle after. State=IDLE. Reset mid-transfer abandons it without reg_done.
- data_oe = ~ulpi_dir combinationally gated with state; data_o = 8'h00 (NOOP) whenever not transmitting.
- States: IDLE, TX_CMD, TX_EXT, TX_DATA, TX_STP, RD_TA, RD_DATA, RX_TA, RX, RX_END.
- IDLE: ulpi_dir=1 -> RX_TA (RX takes priority over request). Else reg_req=1 -> latch addr/data/we, reg_busy=1, -> TX_CMD. Illegal addr (>8'h3F with EXT_ADDR_EN=0) -> reg_done+reg_err next cycle, no bus activity.
- TX_CMD: data_o = {we?2'b10:2'b11, addr6}, addr6 = reg_addr[5:0] or 6'h2F if extended. Hold until nxt=1; then -> TX_EXT (extended), TX_DATA (write), RD_TA (read).
- TX_EXT: data_o=full 8-bit address, hold until nxt=1, then -> TX_DATA / RD_TA.
- TX_DATA: data_o=wdata, on nxt=1 -> TX_STP. TX_STP: ulpi_stp=1, data_o=0 for exactly one cycle, then reg_done, -> IDLE.
- RD_TA: one turnaround cycle with dir=1 (data ignored) -> RD_DATA; RD_DATA: capture data_i into reg_rdata, reg_done; then if dir still 1 -> RX_TA treatment skipped, wait dir=0 -> IDLE.
- Abort: ulpi_dir rising in TX_CMD/TX_EXT/TX_DATA before the accepting nxt -> drop drive same cycle, go RX_TA; request remains latched and restarts at TX_CMD after RX_END. reg_busy stays 1.
- Timeout: counter cleared on each state entry, increments while waiting nxt (TX states) or dir (RD_TA); reaching TIMEOUT -> reg_done+reg_err, -> IDLE, reg_rdata unchanged.
- RX_TA: one cycle, data ignored. RX: per cycle with dir=1: nxt=0 -> RX CMD: status<=data_i, rx_valid=RXCMD_FWD, rx_is_cmd=1; nxt=1 -> rx_valid=1, rx_is_cmd=0. Outputs registered, latency 1 cycle from pad. dir=0 -> RX_END: rx_end=1 one cycle (turnaround), -> IDLE or TX_CMD if retry pending.
- reg_req while busy ignored.

Test Plan:
- Immediate write addr 8'h04 data 8'h45, PHY nxt one cycle after each byte -> data_o 8'h84 then 8'h45, stp one cycle, reg_done=1 reg_err=0.
- Extended read addr 8'h80, PHY returns 8'hA5 -> data_o 8'hEF, 8'h80, turnaround, reg_rdata=8'hA5, reg_done.
- RX burst: dir high, bytes RXCMD 8'h1D (nxt=0), data 8'hC3,8'h00 (nxt=1), dir low -> rx stream cmd/data flags correct, status=8'h1D, rx_end pulse.
- dir rises during TX_CMD of write 8'h0A -> drive released same cycle, RX captured, write retried after rx_end and completes.
- nxt never asserted, TIMEOUT=255 -> reg_done+reg_err at cycle 255; EXT_ADDR_EN=0 with addr 8'h40 -> immediate error, no bus activity.
- Reset asserted mid TX_DATA -> all outputs at reset values, stp=1, no reg_done.
